rf_mp_scoreboard: RTL and testbench

//  Parametrised multi-port integer register file for the LoongArch core, with an

---
 rtl/rf_mp_scoreboard.sv | 102 ++++++++++
 tb/tb_rf_mp_scoreboard.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rf_mp_scoreboard.sv
// Multi-port integer register file with per-register busy scoreboard.
// Two write ports (W0 ALU, W1 load/late), NUM_RD combinational read ports.
// Optional macro RF_BYPASS_EN: forward same-cycle write data and clears to reads.
module rf_mp_scoreboard #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       we0,
  input  logic [ADDR_W-1:0]          wa0,
  input  logic [DATA_W-1:0]          wd0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          wa1,
  input  logic [DATA_W-1:0]          wd1,
  input  logic                       iss_en,
  input  logic [ADDR_W-1:0]          iss_addr,
  output logic [(2**ADDR_W)-1:0]     busy_vec
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam bit          PROT0 = (ZERO_REG != 0);

  logic [DATA_W-1:0] rf [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  set_vec;
  logic [DEPTH-1:0]  clr_vec;
  logic              w0_ok;
  logic              w1_ok;

  // Writes to a protected r0 are dropped
  assign w0_ok = we0 && !(PROT0 && (wa0 == '0));
  assign w1_ok = we1 && !(PROT0 && (wa1 == '0));

  // Register array; W1 is written last so it wins a same-address collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf <= '{default: '0};
    end else begin
      if (w0_ok) rf[wa0] <= wd0;
      if (w1_ok) rf[wa1] <= wd1;
    end
  end

  // Per-register issue (set) and writeback (clear) decode; r0 masked when protected
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (iss_en) set_vec[iss_addr] = 1'b1;
    if (we0)    clr_vec[wa0]      = 1'b1;
    if (we1)    clr_vec[wa1]      = 1'b1;
    if (PROT0) begin
      set_vec[0] = 1'b0;
      clr_vec[0] = 1'b0;
    end
  end

  // Busy state: a new producer issued this cycle overrides a retiring one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= (busy_q & ~clr_vec) | set_vec;
  end

  assign busy_vec = busy_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] d;
    logic              b;

    assign ra = rd_addr[k*ADDR_W +: ADDR_W];

    // Read port k: array/busy lookup, optional same-cycle forwarding, r0 and reset masking
    always_comb begin
      d = rf[ra];
      b = busy_q[ra];
`ifdef RF_BYPASS_EN
      if (we0 && (wa0 == ra)) d = wd0;
      if (we1 && (wa1 == ra)) d = wd1;
      b = busy_q[ra] && !clr_vec[ra];
`else
`endif
      if (PROT0 && (ra == '0)) begin
        d = '0;
        b = 1'b0;
      end
      if (rst) begin
        d = '0;
        b = 1'b0;
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = d;
    assign rd_busy[k]                  = b;
  end

endmodule

// File: tb/tb_rf_mp_scoreboard.sv
// Directed, table-driven bench for rf_mp_scoreboard (default and wide configurations).
module tb_rf_mp_scoreboard;

  logic clk = 1'b0;
  logic rst;

  // Default configuration: DATA_W=32, ADDR_W=5, NUM_RD=2, ZERO_REG=1
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        we0, we1, iss_en;
  logic [4:0]  wa0, wa1, iss_addr;
  logic [31:0] wd0, wd1;
  logic [31:0] busy_vec;

  // Wide configuration: DATA_W=64, ADDR_W=4, NUM_RD=4
  logic [15:0]  w_rd_addr;
  logic [255:0] w_rd_data;
  logic [3:0]   w_rd_busy;
  logic         w_we0, w_we1, w_iss_en;
  logic [3:0]   w_wa0, w_wa1, w_iss_addr;
  logic [63:0]  w_wd0, w_wd1;
  logic [15:0]  w_busy_vec;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rf_mp_scoreboard u_dut (
    .clk(clk), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .busy_vec(busy_vec)
  );

  rf_mp_scoreboard #(.DATA_W(64), .ADDR_W(4), .NUM_RD(4), .ZERO_REG(1)) u_wide (
    .clk(clk), .rst(rst),
    .rd_addr(w_rd_addr), .rd_data(w_rd_data), .rd_busy(w_rd_busy),
    .we0(w_we0), .wa0(w_wa0), .wd0(w_wd0),
    .we1(w_we1), .wa1(w_wa1), .wd1(w_wd1),
    .iss_en(w_iss_en), .iss_addr(w_iss_addr),
    .busy_vec(w_busy_vec)
  );

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        iss;
    logic [4:0]  ia;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] ed0;
    logic [31:0] ed1;
    logic        eb0;
    logic        eb1;
    logic [31:0] ebv;
  } vec_t;

  vec_t tv [9];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; iss_en = 1'b0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; iss_addr = '0;
  endtask

  function automatic logic [63:0] wval(input int unsigned i);
    wval = {32'hA5A50000 + 32'(i), 32'(i) * 32'h01010101};
  endfunction

  initial begin
    // Writes/issues, reads after the edge (bench clears writes so bypass never applies here)
    tv[0] = '{1'b1, 5'd7,  32'h11,        1'b1, 5'd7,  32'h22,   1'b0, 5'd0,  5'd7,  5'd7,  32'h22,        32'h22,   1'b0, 1'b0, 32'h0};
    tv[1] = '{1'b1, 5'd0,  32'hFFFFFFFF,  1'b0, 5'd0,  32'h0,    1'b1, 5'd0,  5'd0,  5'd7,  32'h0,         32'h22,   1'b0, 1'b0, 32'h0};
    tv[2] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,    1'b1, 5'd3,  5'd3,  5'd0,  32'h0,         32'h0,    1'b1, 1'b0, 32'h8};
    tv[3] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd3,  32'h33,   1'b1, 5'd3,  5'd3,  5'd7,  32'h33,        32'h22,   1'b1, 1'b0, 32'h8};
    tv[4] = '{1'b1, 5'd3,  32'h44,        1'b0, 5'd0,  32'h0,    1'b0, 5'd0,  5'd3,  5'd3,  32'h44,        32'h44,   1'b0, 1'b0, 32'h0};
    tv[5] = '{1'b1, 5'd12, 32'hAB,        1'b0, 5'd0,  32'h0,    1'b1, 5'd10, 5'd10, 5'd12, 32'h0,         32'hAB,   1'b1, 1'b0, 32'h400};
    tv[6] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd10, 32'hCD,   1'b1, 5'd12, 5'd10, 5'd12, 32'hCD,        32'hAB,   1'b0, 1'b1, 32'h1000};
    tv[7] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,    1'b1, 5'd12, 5'd31, 5'd12, 32'h0,         32'hAB,   1'b0, 1'b1, 32'h1000};
    tv[8] = '{1'b1, 5'd31, 32'hFFFF0001,  1'b1, 5'd12, 32'h5A5A, 1'b0, 5'd0,  5'd31, 5'd12, 32'hFFFF0001,  32'h5A5A, 1'b0, 1'b0, 32'h0};

    idle();
    rd_addr = '0;
    w_we0 = 1'b0; w_we1 = 1'b0; w_iss_en = 1'b0;
    w_wa0 = '0; w_wa1 = '0; w_wd0 = '0; w_wd1 = '0; w_iss_addr = '0; w_rd_addr = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy_vec", 64'(busy_vec), 64'h0);
    rst = 1'b0;
    rd_addr = {5'd1, 5'd5};
    #1;
    check("reset rd_data", rd_data, 64'h0);

    // Reset asserted mid-cycle while a write is pending
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; iss_en = 1'b1; iss_addr = 5'd9;
    @(posedge clk); #1; idle(); #1;
    check("t1 pre write", 64'(rd_data[31:0]), 64'hDEADBEEF);
    check("t1 pre busy", 64'(busy_vec), 64'h200);
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h77; rd_addr = {5'd9, 5'd5};
    #2 rst = 1'b1;
    #1;
    check("t1 rst rd_data", rd_data, 64'h0);
    check("t1 rst rd_busy", 64'(rd_busy), 64'h0);
    check("t1 rst busy_vec", 64'(busy_vec), 64'h0);
    @(negedge clk);
    rst = 1'b0; idle();
    #1;
    check("t1 after r5", 64'(rd_data[31:0]), 64'h0);
    @(posedge clk); #1;
    check("t1 after edge r5", 64'(rd_data[31:0]), 64'h0);

    // Table of directed vectors
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      we0 = tv[i].we0; wa0 = tv[i].wa0; wd0 = tv[i].wd0;
      we1 = tv[i].we1; wa1 = tv[i].wa1; wd1 = tv[i].wd1;
      iss_en = tv[i].iss; iss_addr = tv[i].ia;
      rd_addr = {tv[i].ra1, tv[i].ra0};
      @(posedge clk); #1; idle(); #1;
      check($sformatf("v%0d rd_data0", i), 64'(rd_data[31:0]),  64'(tv[i].ed0));
      check($sformatf("v%0d rd_data1", i), 64'(rd_data[63:32]), 64'(tv[i].ed1));
      check($sformatf("v%0d rd_busy0", i), 64'(rd_busy[0]),     64'(tv[i].eb0));
      check($sformatf("v%0d rd_busy1", i), 64'(rd_busy[1]),     64'(tv[i].eb1));
      check($sformatf("v%0d busy_vec", i), 64'(busy_vec),       64'(tv[i].ebv));
    end

    // Same-cycle read of a register being written while busy
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h0BAD; iss_en = 1'b1; iss_addr = 5'd9;
    @(posedge clk); #1; idle();
    @(negedge clk);
    rd_addr = {5'd9, 5'd9};
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h1234;
    #1;
`ifdef RF_BYPASS_EN
    check("t5 same cycle data", 64'(rd_data[31:0]), 64'h1234);
    check("t5 same cycle busy", 64'(rd_busy[0]), 64'h0);
`else
    check("t5 same cycle data", 64'(rd_data[31:0]), 64'h0BAD);
    check("t5 same cycle busy", 64'(rd_busy[0]), 64'h1);
`endif
    check("t5 busy_vec unbypassed", 64'(busy_vec[9]), 64'h1);
    @(posedge clk); #1; idle(); #1;
    check("t5 next data", 64'(rd_data[31:0]), 64'h1234);
    check("t5 next busy", 64'(rd_busy[0]), 64'h0);
    // Dual same-address write: W1 has priority on forwarding and in the array
    @(negedge clk);
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h1;
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h2;
    #1;
`ifdef RF_BYPASS_EN
    check("t5 fwd priority", 64'(rd_data[63:32]), 64'h2);
`else
    check("t5 fwd priority", 64'(rd_data[63:32]), 64'h1234);
`endif
    @(posedge clk); #1; idle(); #1;
    check("t5 dual write", 64'(rd_data[63:32]), 64'h2);

    // Wide configuration: distinct values in r1..r15, read four at a time
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      w_we0 = 1'b1; w_wa0 = 4'(i); w_wd0 = wval(i);
      @(posedge clk); #1;
      w_we0 = 1'b0;
    end
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      w_rd_addr = {4'(4*g + 3), 4'(4*g + 2), 4'(4*g + 1), 4'(4*g)};
      #1;
      for (int p = 0; p < 4; p++) begin
        check($sformatf("t6 reg%0d port%0d", 4*g + p, p), w_rd_data[p*64 +: 64],
              (4*g + p == 0) ? 64'h0 : wval(4*g + p));
      end
      check($sformatf("t6 busy grp%0d", g), 64'(w_rd_busy), 64'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
